// File: rtl/main_memory_responder_if.sv
// Cache-to-memory request/response bundle shared by the cache controller (master)
// and the main-memory responder (slave).
interface main_memory_responder_if #(
  parameter int ADDRESS_WORD_SIZE = 32,
  parameter int WORD_SIZE         = 8
);
  logic                         mem_read;
  logic                         mem_write;
  logic [ADDRESS_WORD_SIZE-1:0] addr;
  logic [WORD_SIZE-1:0]         wdata;
  logic                         wdata_valid;
  logic                         wdata_ready;
  logic [WORD_SIZE-1:0]         rdata;
  logic                         rdata_valid;
  logic                         busy;
  logic                         done;

  modport master (
    output mem_read, mem_write, addr, wdata, wdata_valid,
    input  wdata_ready, rdata, rdata_valid, busy, done
  );

  modport slave (
    input  mem_read, mem_write, addr, wdata, wdata_valid,
    output wdata_ready, rdata, rdata_valid, busy, done
  );
endinterface

// File: rtl/main_memory_responder.sv
// Fixed-latency main memory: answers block line-fills and write-backs with a
// one-word-per-cycle burst over a word-addressed backing store.
module main_memory_responder #(
  parameter int ADDRESS_WORD_SIZE = 32,
  parameter int BLOCK_SIZE        = 8,
  parameter int WORD_SIZE         = 8,
  parameter int MEM_DEPTH_WORDS   = 4096,
  parameter int LATENCY           = 4
) (
  input  logic                   clk,
  input  logic                   rst_b,
  main_memory_responder_if.slave bus
);
  localparam int BEAT_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam int IDX_W  = $clog2(MEM_DEPTH_WORDS);
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [2:0] {IDLE, WAIT, RD_BURST, WR_BURST, DONE} state_t;

  state_t               state_q, state_d;
  logic                 op_wr_q, op_wr_d;
  logic [IDX_W-1:0]     base_q, base_d;
  logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;
  logic                 rdata_valid_q, rdata_valid_d;
  logic                 mem_we;
  logic [IDX_W-1:0]     idx;
  logic                 unused_addr_bits;

  logic [WORD_SIZE-1:0] mem [MEM_DEPTH_WORDS];

  // Only the low address bits select a word, so addresses beyond the depth alias.
  assign unused_addr_bits = ^bus.addr[ADDRESS_WORD_SIZE-1:IDX_W];
  assign idx = base_q + IDX_W'(beat_q);

  always_comb begin
    state_d       = state_q;
    op_wr_d       = op_wr_q;
    base_d        = base_q;
    wait_cnt_d    = wait_cnt_q;
    beat_d        = beat_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    mem_we        = 1'b0;
    case (state_q)
      IDLE: begin
        // A simultaneous read is dropped in favour of the write-back.
        if (bus.mem_write || bus.mem_read) begin
          op_wr_d    = bus.mem_write;
          base_d     = bus.addr[IDX_W-1:0] & ~IDX_W'(BLOCK_SIZE - 1);
          wait_cnt_d = CNT_W'(LATENCY - 1);
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt_q == '0) begin
          beat_d  = '0;
          state_d = op_wr_q ? WR_BURST : RD_BURST;
        end else begin
          wait_cnt_d = wait_cnt_q - CNT_W'(1);
        end
      end
      RD_BURST: begin
        rdata_d       = mem[idx];
        rdata_valid_d = 1'b1;
        beat_d        = beat_q + BEAT_W'(1);
        if (beat_q == BEAT_W'(BLOCK_SIZE - 1)) state_d = DONE;
      end
      WR_BURST: begin
        if (bus.wdata_valid) begin
          mem_we = 1'b1;
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == BEAT_W'(BLOCK_SIZE - 1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_q       <= IDLE;
      op_wr_q       <= 1'b0;
      base_q        <= '0;
      wait_cnt_q    <= '0;
      beat_q        <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_wr_q       <= op_wr_d;
      base_q        <= base_d;
      wait_cnt_q    <= wait_cnt_d;
      beat_q        <= beat_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
    end
  end

  // Backing store survives reset; writes are gated by state, which reset forces to IDLE.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= bus.wdata;
  end

  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.wdata_ready = (state_q == WR_BURST);
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
endmodule

// File: tb/tb_main_memory_responder.sv
// Scoreboard bench for main_memory_responder: directed block transfers followed by
// random traffic, checked against an array model of the backing store.
module tb_main_memory_responder;
  localparam int AW = 32, BS = 8, WW = 8, DEPTH = 4096, LAT = 4;

  logic clk = 1'b0;
  logic rst_b = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  main_memory_responder_if #(.ADDRESS_WORD_SIZE(AW), .WORD_SIZE(WW)) bus ();

  main_memory_responder #(
    .ADDRESS_WORD_SIZE(AW), .BLOCK_SIZE(BS), .WORD_SIZE(WW),
    .MEM_DEPTH_WORDS(DEPTH), .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst_b(rst_b),
    .bus(bus)
  );

  logic [WW-1:0] ref_mem [DEPTH];
  int unsigned   wbases[$];
  logic [WW-1:0] sb[$];
  logic [WW-1:0] mon_exp;
  int n_checks = 0, n_fail = 0, done_cnt = 0, rv_cnt = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every presented read beat must match the oldest expected word.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) done_cnt++;
      if (bus.rdata_valid === 1'b1) begin
        rv_cnt++;
        if (sb.size() == 0) begin
          check("unexpected_rdata_valid", 32'd1, 32'd0);
        end else begin
          mon_exp = sb.pop_front();
          check("rdata", 32'(bus.rdata), 32'(mon_exp));
        end
      end
    end
  end

  task automatic do_read(input logic [AW-1:0] a, input bit poke_wait, input bit reset_mid);
    int unsigned base;
    int t, first, nbeats, done_at;
    @(negedge clk);
    base = (a % DEPTH) & ~(BS - 1);
    for (int i = 0; i < BS; i++) sb.push_back(ref_mem[(base + i) % DEPTH]);
    bus.addr = a;
    bus.mem_read = 1'b1;
    t = cyc + 1;
    @(negedge clk);
    bus.mem_read = 1'b0;
    first = -1; nbeats = 0; done_at = -1;
    for (int k = 0; k < 40 && done_at < 0; k++) begin
      bus.mem_write = (poke_wait && cyc == t + 2);
      if (bus.rdata_valid === 1'b1) begin
        if (first < 0) first = cyc;
        nbeats++;
        if (reset_mid && nbeats == 3) begin
          #2 rst_b = 1'b1;
          #1;
          check("rst_rdata_valid", 32'(bus.rdata_valid), 32'd0);
          check("rst_busy", 32'(bus.busy), 32'd0);
          check("rst_done", 32'(bus.done), 32'd0);
          check("rst_wdata_ready", 32'(bus.wdata_ready), 32'd0);
          check("rst_rdata", 32'(bus.rdata), 32'd0);
          sb.delete();
          @(negedge clk);
          rst_b = 1'b0;
          return;
        end
      end
      if (bus.done === 1'b1) done_at = cyc;
      @(negedge clk);
    end
    bus.mem_write = 1'b0;
    if (done_at < 0) begin
      check("read_done_timeout", 32'd0, 32'd1);
    end else begin
      check("read_done_latency", 32'(done_at - t), 32'(LAT + BS));
      check("read_first_beat", 32'(first - t), 32'(LAT + 1));
      check("read_beats", 32'(nbeats), 32'(BS));
      check("read_busy_after_done", 32'(bus.busy), 32'd0);
      check("read_done_pulse", 32'(bus.done), 32'd0);
    end
  endtask

  // mode 0: continuous valid, 1: valid toggles starting low, 2: random gaps.
  task automatic do_write(input logic [AW-1:0] a, input int mode, input bit fixed, input bit also_read);
    int unsigned base;
    int t, i, first_rdy, nrdy, last_drv, done_at, rv0;
    bit ph, v;
    logic [WW-1:0] d;
    @(negedge clk);
    base = (a % DEPTH) & ~(BS - 1);
    wbases.push_back(base);
    bus.addr = a;
    bus.mem_write = 1'b1;
    bus.mem_read = also_read;
    t = cyc + 1;
    @(negedge clk);
    bus.mem_write = 1'b0;
    bus.mem_read = 1'b0;
    i = 0; first_rdy = -1; nrdy = 0; last_drv = -1; done_at = -1; rv0 = rv_cnt; ph = 1'b0;
    for (int k = 0; k < 80 && done_at < 0; k++) begin
      bus.wdata_valid = 1'b0;
      if (bus.wdata_ready === 1'b1) begin
        if (first_rdy < 0) first_rdy = cyc;
        nrdy++;
        if (i < BS) begin
          v = (mode == 0) ? 1'b1 : (mode == 1) ? ph : ($urandom_range(0, 3) != 0);
          ph = !ph;
          if (v) begin
            d = fixed ? WW'(8'h10 + i) : WW'($urandom);
            bus.wdata = d;
            bus.wdata_valid = 1'b1;
            ref_mem[(base + i) % DEPTH] = d;
            i++;
            last_drv = cyc;
          end
        end
      end
      if (bus.done === 1'b1) done_at = cyc;
      @(negedge clk);
    end
    bus.wdata_valid = 1'b0;
    check("write_no_rdata_valid", 32'(rv_cnt - rv0), 32'd0);
    if (done_at < 0) begin
      check("write_done_timeout", 32'd0, 32'd1);
    end else begin
      check("write_beats", 32'(i), 32'(BS));
      check("write_done_after_last_beat", 32'(done_at), 32'(last_drv + 1));
      check("write_first_ready", 32'(first_rdy - t), 32'(LAT));
      check("write_busy_after_done", 32'(bus.busy), 32'd0);
      if (mode == 0) begin
        check("write_ready_cycles", 32'(nrdy), 32'(BS));
        check("write_done_latency", 32'(done_at - t), 32'(LAT + BS));
      end
      if (mode == 1) check("write_gap_done_latency", 32'(done_at - t), 32'(LAT + 2 * BS));
    end
  endtask

  initial begin
    int d0;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.addr = '0;
    bus.wdata = '0;
    bus.wdata_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_rdata_valid", 32'(bus.rdata_valid), 32'd0);
    check("reset_wdata_ready", 32'(bus.wdata_ready), 32'd0);
    check("reset_rdata", 32'(bus.rdata), 32'd0);
    rst_b = 1'b0;
    repeat (2) @(negedge clk);

    do_write(32'h40, 0, 1'b1, 1'b0);
    do_read(32'h47, 1'b0, 1'b0);
    do_write(32'h80, 1, 1'b0, 1'b0);
    do_read(32'h80, 1'b0, 1'b0);
    do_write(32'h100, 0, 1'b0, 1'b1);
    do_read(32'h100, 1'b0, 1'b0);
    do_read(32'h40, 1'b1, 1'b0);
    d0 = done_cnt;
    repeat (25) @(negedge clk);
    check("no_extra_done", 32'(done_cnt), 32'(d0));
    check("idle_after_ignored_req", 32'(bus.busy), 32'd0);
    do_write(32'h1040, 0, 1'b0, 1'b0);
    do_read(32'h0040, 1'b0, 1'b0);
    do_read(32'h40, 1'b0, 1'b1);
    do_read(32'h40, 1'b0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 1) == 1 || wbases.size() == 0)
        do_write(AW'($urandom_range(0, 16'h3fff)), 2, 1'b0, 1'b0);
      else
        do_read(AW'(wbases[$urandom_range(0, wbases.size() - 1)] + $urandom_range(0, BS - 1)), 1'b0, 1'b0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
